// File: rtl/axi_arb_pkg.sv
// Shared state and transfer-type encodings for the round-robin slot arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } slot_state_e;

  typedef enum logic {
    XFER_RD = 1'b0,
    XFER_WR = 1'b1
  } xfer_e;

  localparam int IDX_NONE = 0;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping to the bottom.
module rr_picker
  import axi_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    gnt   = '0;
    idx   = IW'(IDX_NONE);
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) < ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Per-slot round-robin read/write arbiter with owner tracking.
// Optional sticky per-slot watchdog is built when ARB_WATCHDOG_EN is defined.
//
// state | meaning
// IDLE  | no connection; indices show the combinational grant, if any
// RD    | read connection held by owner until the last R beat is accepted
// WR    | write connection held by owner until the B response is accepted
module axi_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M       = 3,
  parameter int NUM_S       = 6,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MIDX_BITS   = $clog2(NUM_M + 1),
  parameter int SIDX_BITS   = $clog2(NUM_S + 2)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_S:0][NUM_M-1:0]       r_req,
  input  logic [NUM_S:0][NUM_M-1:0]       w_req,
  input  logic [NUM_S:0]                  arready_s,
  input  logic [NUM_S:0]                  awready_s,
  input  logic [NUM_S:0]                  rvalid_s,
  input  logic [NUM_S:0]                  rlast_s,
  input  logic [NUM_S:0]                  bvalid_s,
  input  logic [NUM_M-1:0]                rready_m,
  input  logic [NUM_M-1:0]                bready_m,
  output logic [NUM_S:0][MIDX_BITS-1:0]   s_ridx,
  output logic [NUM_S:0][MIDX_BITS-1:0]   s_widx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0] m_ridx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0] m_widx
`ifdef ARB_WATCHDOG_EN
  ,
  output logic [NUM_S:0]                  timeout
`endif
);

  localparam int NSLOT = NUM_S + 1;

  if (TIMEOUT_CYC < 1 || NUM_M < 1 || NUM_S < 1) begin : g_bad_params
    $error("axi_rr_arbiter: NUM_M, NUM_S and TIMEOUT_CYC must be positive");
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`endif

  logic [NUM_S:0][NUM_M-1:0] rd_held;
  logic [NUM_S:0][NUM_M-1:0] wr_held;

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    slot_state_e          state_q, state_d;
    logic [MIDX_BITS-1:0] owner_q, owner_d;
    logic [MIDX_BITS-1:0] ptr_q, ptr_d;
    xfer_e                pri_q, pri_d;
    logic [NUM_M-1:0]     owner_oh;
    logic [NUM_M-1:0]     excl_rd, excl_wr;
    logic [NUM_M-1:0]     lower_rd, lower_wr;
    logic [NUM_M-1:0]     rd_elig, wr_elig;
    logic [NUM_M-1:0]     gnt_oh, new_rd, new_wr;
    logic [MIDX_BITS-1:0] gnt_idx;
    logic                 gnt_found, rel, open, rd_pick, wr_pick;

    always_comb begin
      owner_oh = '0;
      for (int m = 0; m < NUM_M; m++) owner_oh[m] = (owner_q == MIDX_BITS'(m));
    end

    assign rd_held[s] = (state_q == RD) ? owner_oh : '0;
    assign wr_held[s] = (state_q == WR) ? owner_oh : '0;

    always_comb begin
      excl_rd = '0;
      excl_wr = '0;
      for (int t = 0; t < NSLOT; t++) begin
        if (t != s) begin
          excl_rd = excl_rd | rd_held[t];
          excl_wr = excl_wr | wr_held[t];
        end
      end
    end

    // Grants made this cycle by lower slots also exclude a master, so two idle
    // slots can never hand the same master the same transfer type at one edge.
    if (s == 0) begin : g_first
      assign lower_rd = '0;
      assign lower_wr = '0;
    end else begin : g_next
      assign lower_rd = g_slot[s-1].lower_rd | g_slot[s-1].new_rd;
      assign lower_wr = g_slot[s-1].lower_wr | g_slot[s-1].new_wr;
    end

    always_comb begin
      rel = 1'b0;
      case (state_q)
        RD:      rel = rvalid_s[s] & rlast_s[s] & |(rready_m & owner_oh);
        WR:      rel = bvalid_s[s] & |(bready_m & owner_oh);
        default: rel = 1'b0;
      endcase
    end

    assign open    = !rst && ((state_q == IDLE) || rel);
    assign rd_elig = (open && arready_s[s])  ? (r_req[s] & ~excl_rd & ~lower_rd) : '0;
    assign wr_elig = (open && awready_s[s]) ? (w_req[s] & ~excl_wr & ~lower_wr) : '0;

    rr_picker #(.N(NUM_M), .IW(MIDX_BITS)) u_pick (
      .req   (rd_elig | wr_elig),
      .ptr   (ptr_q),
      .gnt   (gnt_oh),
      .idx   (gnt_idx),
      .found (gnt_found)
    );

    assign rd_pick = gnt_found && |(gnt_oh & rd_elig) &&
                     (!(|(gnt_oh & wr_elig)) || (pri_q == XFER_RD));
    assign wr_pick = gnt_found && |(gnt_oh & wr_elig) && !rd_pick;
    assign new_rd  = rd_pick ? gnt_oh : '0;
    assign new_wr  = wr_pick ? gnt_oh : '0;

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      pri_d   = pri_q;
      if (rel) state_d = IDLE;
      if (rd_pick || wr_pick) begin
        state_d = rd_pick ? RD : WR;
        owner_d = gnt_idx;
        ptr_d   = (gnt_idx == MIDX_BITS'(NUM_M - 1)) ? '0 : gnt_idx + MIDX_BITS'(1);
        pri_d   = rd_pick ? XFER_WR : XFER_RD;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
        pri_q   <= XFER_RD;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        pri_q   <= pri_d;
      end
    end

    // A held connection always shows its owner; a re-grant in the release
    // cycle only becomes visible once registered.
    assign s_ridx[s] = (state_q == RD)               ? owner_q + MIDX_BITS'(1) :
                       ((state_q == IDLE) && rd_pick) ? gnt_idx + MIDX_BITS'(1) :
                                                        MIDX_BITS'(IDX_NONE);
    assign s_widx[s] = (state_q == WR)               ? owner_q + MIDX_BITS'(1) :
                       ((state_q == IDLE) && wr_pick) ? gnt_idx + MIDX_BITS'(1) :
                                                        MIDX_BITS'(IDX_NONE);

`ifdef ARB_WATCHDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q;

    always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) || rel)           cnt_d = '0;
      else if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_W'(TIMEOUT_CYC)) to_q <= 1'b1;
      end
    end

    assign timeout[s] = to_q;
`endif
  end

  always_comb begin
    m_ridx = '0;
    m_widx = '0;
    for (int s = 0; s < NSLOT; s++) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (s_ridx[s] == MIDX_BITS'(m + 1)) m_ridx[m] = SIDX_BITS'(s + 1);
        if (s_widx[s] == MIDX_BITS'(m + 1)) m_widx[m] = SIDX_BITS'(s + 1);
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: per-cycle vector table plus reset and watchdog sequences.
module tb_axi_rr_arbiter;

  localparam int NM  = 3;
  localparam int NS  = 6;
  localparam int NSL = NS + 1;
  localparam int MB  = 2;
  localparam int SB  = 3;
`ifdef ARB_WATCHDOG_EN
  localparam int TO  = 8;
`else
  localparam int TO  = 1024;
`endif

  typedef logic [NS:0][NM-1:0] req_t;
  typedef logic [NS:0][MB-1:0] sidx_t;
  typedef logic [NM-1:0][SB-1:0] midx_t;
  typedef logic [NS:0] slot_t;

  typedef struct {
    string name;
    req_t  rq;
    req_t  wq;
    slot_t ar;
    slot_t rv;
    slot_t rl;
    slot_t bv;
    sidx_t esr;
    sidx_t esw;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  req_t  r_req, w_req;
  slot_t arready_s, awready_s, rvalid_s, rlast_s, bvalid_s;
  logic [NM-1:0] rready_m, bready_m;
  sidx_t s_ridx, s_widx;
  midx_t m_ridx, m_widx;
`ifdef ARB_WATCHDOG_EN
  slot_t timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  axi_rr_arbiter #(.NUM_M(NM), .NUM_S(NS), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .r_req     (r_req),
    .w_req     (w_req),
    .arready_s (arready_s),
    .awready_s (awready_s),
    .rvalid_s  (rvalid_s),
    .rlast_s   (rlast_s),
    .bvalid_s  (bvalid_s),
    .rready_m  (rready_m),
    .bready_m  (bready_m),
    .s_ridx    (s_ridx),
    .s_widx    (s_widx),
    .m_ridx    (m_ridx),
    .m_widx    (m_widx)
`ifdef ARB_WATCHDOG_EN
    ,
    .timeout   (timeout)
`endif
  );

  function automatic req_t rq1(int s, logic [NM-1:0] m);
    req_t v = '0;
    v[s] = m;
    return v;
  endfunction

  function automatic sidx_t sx(int s, int val);
    sidx_t v = '0;
    v[s] = MB'(val);
    return v;
  endfunction

  function automatic slot_t sb(int s);
    slot_t v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Inverse map: which slot (+1) each master is connected to.
  function automatic midx_t to_m(sidx_t e);
    midx_t r = '0;
    for (int s = 0; s < NSL; s++)
      if (e[s] != '0) r[int'(e[s]) - 1] = SB'(s + 1);
    return r;
  endfunction

  task automatic add(string nm, req_t rq, req_t wq, slot_t rv, slot_t rl, slot_t bv,
                     sidx_t esr, sidx_t esw);
    vec_t v;
    v.name = nm; v.rq = rq; v.wq = wq; v.ar = '1;
    v.rv = rv; v.rl = rl; v.bv = bv; v.esr = esr; v.esw = esw;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idx(string nm, sidx_t esr, sidx_t esw);
    chk({nm, " s_ridx"}, 64'(s_ridx), 64'(esr));
    chk({nm, " s_widx"}, 64'(s_widx), 64'(esw));
    chk({nm, " m_ridx"}, 64'(m_ridx), 64'(to_m(esr)));
    chk({nm, " m_widx"}, 64'(m_widx), 64'(to_m(esw)));
  endtask

  task automatic clear_in();
    r_req = '0; w_req = '0; rvalid_s = '0; rlast_s = '0; bvalid_s = '0;
    arready_s = '1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    awready_s = '1;
    rready_m  = '1;
    bready_m  = '1;

    // slot 2 three-master rotation, 1-beat bursts, no bubbles
    add("rr c0", rq1(2, 3'b111), '0, '0,    '0,    '0, sx(2, 1), '0);
    add("rr c1", rq1(2, 3'b111), '0, sb(2), sb(2), '0, sx(2, 1), '0);
    add("rr c2", rq1(2, 3'b111), '0, sb(2), sb(2), '0, sx(2, 2), '0);
    add("rr c3", rq1(2, 3'b111), '0, sb(2), sb(2), '0, sx(2, 3), '0);
    add("rr c4", '0,             '0, sb(2), sb(2), '0, sx(2, 1), '0);
    add("rr idle", '0, '0, '0, '0, '0, '0, '0);
    // master 1 read+write at slot 0: read first, write straight after RLAST
    add("rw d0", rq1(0, 3'b010), rq1(0, 3'b010), '0,    '0,    '0,    sx(0, 2), '0);
    add("rw d1", '0,             rq1(0, 3'b010), sb(0), '0,    '0,    sx(0, 2), '0);
    add("rw d2", '0,             rq1(0, 3'b010), sb(0), sb(0), '0,    sx(0, 2), '0);
    add("rw d3", '0,             rq1(0, 3'b010), '0,    '0,    '0,    '0, sx(0, 2));
    add("rw d4", '0,             '0,             '0,    '0,    sb(0), '0, sx(0, 2));
    add("rw idle", '0, '0, '0, '0, '0, '0, '0);
    // master 0 holds slot 1, slot 3 waits for the release
    add("hold e0", rq1(1, 3'b001), '0, '0,    '0,    '0, sx(1, 1), '0);
    add("hold e1", rq1(3, 3'b001), '0, '0,    '0,    '0, sx(1, 1), '0);
    add("hold e2", rq1(3, 3'b001), '0, sb(1), sb(1), '0, sx(1, 1), '0);
    add("hold e3", rq1(3, 3'b001), '0, '0,    '0,    '0, sx(3, 1), '0);
    add("hold e4", '0,             '0, sb(3), sb(3), '0, sx(3, 1), '0);
    add("hold idle", '0, '0, '0, '0, '0, '0, '0);
    // master 2 asks slots 4 and 5 in the same cycle: only one may win
    add("tie f0", rq1(4, 3'b100) | rq1(5, 3'b100), '0, '0,    '0,    '0, sx(4, 3), '0);
    add("tie f1", rq1(5, 3'b100),                  '0, sb(4), sb(4), '0, sx(4, 3), '0);
    add("tie f2", rq1(5, 3'b100),                  '0, '0,    '0,    '0, sx(5, 3), '0);
    add("tie f3", '0,                              '0, sb(5), sb(5), '0, sx(5, 3), '0);
    add("tie idle", '0, '0, '0, '0, '0, '0, '0);
    // arready gating on the default slot
    add("ar low",  rq1(6, 3'b001), '0, '0,    '0,    '0, '0,       '0);
    vecs[vecs.size() - 1].ar = ~sb(6);
    add("ar high", rq1(6, 3'b001), '0, '0,    '0,    '0, sx(6, 1), '0);
    add("ar rel",  '0,             '0, sb(6), sb(6), '0, sx(6, 1), '0);
    add("ar idle", '0, '0, '0, '0, '0, '0, '0);

    // reset state, with requests present to show grants are blocked
    r_req = rq1(2, 3'b111);
    w_req = rq1(5, 3'b011);
    repeat (2) @(negedge clk);
    chk_idx("reset", '0, '0);
`ifdef ARB_WATCHDOG_EN
    chk("reset timeout", 64'(timeout), 64'(0));
`endif
    clear_in();
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      r_req = vecs[i].rq; w_req = vecs[i].wq; arready_s = vecs[i].ar;
      rvalid_s = vecs[i].rv; rlast_s = vecs[i].rl; bvalid_s = vecs[i].bv;
      @(negedge clk);
      chk_idx(vecs[i].name, vecs[i].esr, vecs[i].esw);
    end

    // async reset in the middle of a 4-beat burst; slot 2 pointer is 1 here
    @(posedge clk); #1;
    clear_in();
    r_req = rq1(2, 3'b110);
    @(negedge clk);
    chk_idx("burst grant", sx(2, 2), '0);
    @(posedge clk); #1;
    rvalid_s = sb(2);
    @(negedge clk);
    chk_idx("burst beat1", sx(2, 2), '0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 chk_idx("async rst", '0, '0);
    @(negedge clk);
    chk_idx("rst held", '0, '0);
    rvalid_s = '0;
    #1 rst = 1'b0;
    #1 chk_idx("post rst grant", sx(2, 2), '0);
    @(posedge clk); #1;
    r_req = '0;
    rvalid_s = sb(2);
    rlast_s = sb(2);
    @(negedge clk);
    chk_idx("post rst owner", sx(2, 2), '0);
    @(posedge clk); #1;
    clear_in();
    @(negedge clk);
    chk_idx("post rst idle", '0, '0);

`ifdef ARB_WATCHDOG_EN
    // write to the default slot with B withheld past the watchdog threshold
    @(posedge clk); #1;
    w_req = rq1(6, 3'b001);
    @(negedge clk);
    chk_idx("wd grant", '0, sx(6, 1));
    @(posedge clk); #1;
    w_req = '0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("wd before", 64'(timeout[6]), 64'(0));
    chk_idx("wd hold", '0, sx(6, 1));
    @(posedge clk);
    @(negedge clk);
    chk("wd reached", 64'(timeout), 64'(sb(6)));
    @(posedge clk); #1;
    bvalid_s = sb(6);
    @(negedge clk);
    chk_idx("wd b cycle", '0, sx(6, 1));
    @(posedge clk); #1;
    bvalid_s = '0;
    @(negedge clk);
    chk_idx("wd released", '0, '0);
    chk("wd sticky", 64'(timeout), 64'(sb(6)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
